// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer: random hold after all lights lit, lights-out pulse,
// then reaction timing in prescaled ticks with jump-start detection.
module f1_reaction_timer #(
   parameter int DIV       = 1000,
   parameter int CNT_W     = 16,
   parameter int MIN_DELAY = 100
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [7:0]       i_lights,
   input  logic             i_button,
   output logic             o_lights_off,
   output logic [CNT_W-1:0] o_react_time,
   output logic             o_valid,
   output logic             o_jump_start,
   output logic             o_busy
);

   localparam int PW = $clog2(DIV);
   localparam int DW = $clog2(MIN_DELAY + 128);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_DELAY,
      S_TIMING
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [PW-1:0]    r_presc;
   logic [6:0]       r_lfsr;
   logic             r_btn_q;
   logic [DW-1:0]    r_dcnt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_rt;
   logic             r_lo;
   logic             r_valid;
   logic             r_jump;

   logic w_btn_rise;
   logic w_tick;
   logic w_all_lit;
   logic w_expire;
   logic w_enter_delay;
   logic w_enter_timing;
   logic w_set_jump;
   logic w_clr_jump;
   logic w_capture;

   assign w_btn_rise = i_button & ~r_btn_q;
   assign w_tick     = (r_presc == PW'(DIV - 1));
   assign w_all_lit  = (i_lights == 8'hFF);
   assign w_expire   = w_tick && (r_dcnt == DW'(1));

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state decode; an early press always beats lights/expiry
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (i_start) w_next = S_ARMED;
         S_ARMED:  if (w_btn_rise) w_next = S_IDLE;
                   else if (w_all_lit) w_next = S_DELAY;
         S_DELAY:  if (w_btn_rise) w_next = S_IDLE;
                   else if (w_expire) w_next = S_TIMING;
         S_TIMING: if (w_btn_rise) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Per-state event decode feeding the registered outputs
   always_comb begin
      w_clr_jump     = 1'b0;
      w_set_jump     = 1'b0;
      w_enter_delay  = 1'b0;
      w_enter_timing = 1'b0;
      w_capture      = 1'b0;
      case (r_state)
         S_IDLE:  w_clr_jump = i_start;
         S_ARMED: begin
            w_set_jump    = w_btn_rise;
            w_enter_delay = ~w_btn_rise & w_all_lit;
         end
         S_DELAY: begin
            w_set_jump     = w_btn_rise;
            w_enter_timing = ~w_btn_rise & w_expire;
         end
         S_TIMING: w_capture = w_btn_rise;
         default: ;
      endcase
   end

   assign o_busy = (r_state != S_IDLE);

   // Tick prescaler, realigned at the start of each timed phase
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_presc <= '0;
      else if (w_enter_delay || w_enter_timing || w_tick)
         r_presc <= '0;
      else
         r_presc <= r_presc + PW'(1);
   end

   // Free-running x^7+x^6+1 LFSR and button history
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lfsr  <= 7'h01;
         r_btn_q <= 1'b0;
      end else begin
         r_lfsr  <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
         r_btn_q <= i_button;
      end
   end

   // Hold countdown in ticks
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_dcnt <= '0;
      else if (w_enter_delay)
         r_dcnt <= DW'(MIN_DELAY) + DW'(r_lfsr);
      else if (r_state == S_DELAY && w_tick)
         r_dcnt <= r_dcnt - DW'(1);
   end

   // Saturating reaction counter
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_cnt <= '0;
      else if (w_enter_timing)
         r_cnt <= '0;
      else if (r_state == S_TIMING && w_tick && r_cnt != '1)
         r_cnt <= r_cnt + CNT_W'(1);
   end

   // Registered result, pulses and sticky jump flag
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lo    <= 1'b0;
         r_valid <= 1'b0;
         r_rt    <= '0;
         r_jump  <= 1'b0;
      end else begin
         r_lo    <= w_enter_timing;
         r_valid <= w_capture;
         if (w_capture)       r_rt   <= r_cnt;
         if (w_set_jump)      r_jump <= 1'b1;
         else if (w_clr_jump) r_jump <= 1'b0;
      end
   end

   assign o_lights_off = r_lo;
   assign o_valid      = r_valid;
   assign o_react_time = r_rt;
   assign o_jump_start = r_jump;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Randomized bench for f1_reaction_timer: two instances (normal and
// narrow saturating counter) checked against timing arithmetic.
module tb_f1_reaction_timer;

   localparam int MIND = 2;

   logic        clk;
   logic        rst;
   logic        start  [2];
   logic [7:0]  lights [2];
   logic        button [2];
   logic        lo     [2];
   logic        vl     [2];
   logic        js     [2];
   logic        bz     [2];
   logic [15:0] rta;
   logic [3:0]  rtb;

   int n_chk = 0;
   int n_err = 0;
   int since_rst = 0;
   int m_rt [2];

   f1_reaction_timer #(.DIV(4), .CNT_W(16), .MIN_DELAY(MIND)) u_a (
      .i_clk(clk), .i_rst(rst), .i_start(start[0]),
      .i_lights(lights[0]), .i_button(button[0]),
      .o_lights_off(lo[0]), .o_react_time(rta), .o_valid(vl[0]),
      .o_jump_start(js[0]), .o_busy(bz[0])
   );

   f1_reaction_timer #(.DIV(2), .CNT_W(4), .MIN_DELAY(MIND)) u_b (
      .i_clk(clk), .i_rst(rst), .i_start(start[1]),
      .i_lights(lights[1]), .i_button(button[1]),
      .o_lights_off(lo[1]), .o_react_time(rtb), .o_valid(vl[1]),
      .o_jump_start(js[1]), .o_busy(bz[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int lfsr_after(input int k);
      logic [6:0] v;
      v = 7'h01;
      for (int i = 0; i < k % 127; i++) v = {v[5:0], v[6] ^ v[5]};
      return int'(v);
   endfunction

   function automatic int div_of(input int s);
      return (s == 0) ? 4 : 2;
   endfunction

   function automatic int max_of(input int s);
      return (s == 0) ? 65535 : 15;
   endfunction

   function automatic int get_rt(input int s);
      return (s == 0) ? int'(rta) : int'(rtb);
   endfunction

   task automatic cyc1();
      @(posedge clk);
      if (rst) since_rst = 0;
      else     since_rst++;
      #1;
   endtask

   // mode: 0 normal, 1 jump in ARMED, 2 jump in DELAY,
   //       3 press with all-lit, 4 reset during TIMING
   task automatic run_round(input int s, input int mode, input int p);
      int n, l, k0, cnt, at, q, e;
      start[s] = 1'b1;
      cyc1();
      start[s]  = 1'b0;
      lights[s] = 8'h00;
      chk("start_busy", bz[s], 1);
      chk("start_js", js[s], 0);
      chk("start_rt", get_rt(s), m_rt[s]);
      repeat ($urandom_range(0, 4)) begin
         lights[s] = 8'($urandom_range(0, 254));
         cyc1();
      end
      if (mode == 1 || mode == 3) begin
         button[s] = 1'b1;
         if (mode == 3) lights[s] = 8'hFF;
         cyc1();
         button[s] = 1'b0;
         lights[s] = 8'h00;
         chk("jmpA_js", js[s], 1);
         chk("jmpA_busy", bz[s], 0);
         chk("jmpA_valid", vl[s], 0);
         chk("jmpA_lo", lo[s], 0);
         chk("jmpA_rt", get_rt(s), m_rt[s]);
         cyc1();
         return;
      end
      lights[s] = 8'hFF;
      l = lfsr_after(since_rst);
      n = (MIND + l) * div_of(s);
      cyc1();
      lights[s] = 8'($urandom_range(0, 1) ? 0 : 255);
      if (mode == 2) begin
         k0  = $urandom_range(1, n);
         cnt = 0;
         for (int k = 1; k <= k0; k++) begin
            if (k == k0) button[s] = 1'b1;
            cyc1();
            if (lo[s]) cnt++;
         end
         button[s] = 1'b0;
         chk("jmpD_js", js[s], 1);
         chk("jmpD_busy", bz[s], 0);
         repeat (n + 2) begin
            cyc1();
            if (lo[s]) cnt++;
         end
         chk("jmpD_lo", cnt, 0);
         lights[s] = 8'h00;
         return;
      end
      at  = 0;
      cnt = 0;
      for (int k = 1; k <= n; k++) begin
         cyc1();
         if (lo[s]) begin
            cnt++;
            if (at == 0) at = k;
         end
      end
      lights[s] = 8'h00;
      chk("lo_at", at, n);
      chk("lo_cnt", cnt, 1);
      chk("timing_busy", bz[s], 1);
      if (mode == 4) begin
         repeat (p) cyc1();
         rst = 1'b1;
         cyc1();
         rst = 1'b0;
         chk("rstT_busy", bz[s], 0);
         chk("rstT_rt", get_rt(s), 0);
         chk("rstT_valid", vl[s], 0);
         chk("rstT_lo", lo[s], 0);
         m_rt[0] = 0;
         m_rt[1] = 0;
         cyc1();
         chk("rstT_valid2", vl[s], 0);
         return;
      end
      q = 0;
      for (int i = 1; i <= p; i++) begin
         if (i == p) button[s] = 1'b1;
         cyc1();
         if (i < p && (vl[s] || lo[s])) q++;
      end
      chk("timing_quiet", q, 0);
      e = (p - 1) / div_of(s);
      if (e > max_of(s)) e = max_of(s);
      m_rt[s] = e;
      chk("react_valid", vl[s], 1);
      chk("react_time", get_rt(s), e);
      chk("react_busy", bz[s], 0);
      button[s] = 1'b0;
      cyc1();
      chk("valid_1cyc", vl[s], 0);
      chk("rt_hold", get_rt(s), e);
   endtask

   initial begin
      int s, md;
      for (int i = 0; i < 2; i++) begin
         start[i]  = 1'b0;
         lights[i] = 8'h00;
         button[i] = 1'b0;
         m_rt[i]   = 0;
      end
      rst      = 1'b1;
      start[0] = 1'b1;
      start[1] = 1'b1;
      cyc1();
      cyc1();
      start[0] = 1'b0;
      start[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("rst_lo", lo[i], 0);
         chk("rst_valid", vl[i], 0);
         chk("rst_js", js[i], 0);
         chk("rst_busy", bz[i], 0);
         chk("rst_rt", get_rt(i), 0);
      end
      rst = 1'b0;
      cyc1();
      chk("rst_start_ign", bz[0], 0);

      run_round(0, 0, 14);
      run_round(0, 1, 0);
      run_round(0, 0, $urandom_range(1, 40));
      run_round(0, 2, 0);
      run_round(0, 0, $urandom_range(1, 40));
      run_round(0, 3, 0);

      button[0] = 1'b1;
      cyc1();
      start[0] = 1'b1;
      cyc1();
      start[0] = 1'b0;
      repeat (3) cyc1();
      chk("held_busy", bz[0], 1);
      chk("held_js", js[0], 0);
      button[0] = 1'b0;
      cyc1();
      button[0] = 1'b1;
      cyc1();
      button[0] = 1'b0;
      chk("repress_js", js[0], 1);
      chk("repress_busy", bz[0], 0);
      cyc1();

      run_round(1, 0, 45);
      run_round(1, 0, $urandom_range(1, 20));
      for (int r = 0; r < 10; r++) begin
         s  = $urandom_range(0, 1);
         md = $urandom_range(0, 3);
         if (md == 3) md = 0;
         run_round(s, md, $urandom_range(1, 60));
      end
      run_round(0, 4, 5);
      run_round(1, 0, $urandom_range(1, 60));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/f1_reaction_timer.md
Name: f1_reaction_timer

Overview:
- Downstream consumer of the F1 start-light sequencer. Watches its 8-bit light pattern.
- Once all eight lights are lit, waits a pseudo-random hold time, then requests "lights out".
- After lights out, measures the player's reaction time in ticks until the button is pressed.
- Flags a jump start if the button is pressed before lights out. Results drive the seven-segment display path.

Parameters:
- DIV, 1000, clk cycles per timing tick (prescaler period); legal values are 2 and above.
- CNT_W, 16, width of the reaction-time counter in ticks.
- MIN_DELAY, 100, fixed hold ticks added to the random component.

Ports:
- clk  in  1  system clock; every register is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a new round.
- lights  in  8  light pattern from the sequencer; 8'hFF means all lit.
- button  in  1  player button, already synchronised, active high, level.
- lights_off  out  1  one-cycle pulse at the end of the random hold.
- react_time  out  CNT_W  measured reaction time in ticks; held until the next start.
- valid  out  1  one-cycle pulse when react_time is updated.
- jump_start  out  1  sticky flag for an early press; cleared on start.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - State returns to IDLE.
  - lights_off = 0, valid = 0, jump_start = 0, react_time = 0, busy = 0.
  - Prescaler = 0, LFSR = 7'h01, button_q = 0.
  - Reset mid-round aborts the round; no valid pulse and no lights_off pulse are issued.
- Button edge:
  - btn_rise = button & ~button_q, where button_q is registered every cycle.
  - Only rising edges count; holding the button is a single event.
- LFSR:
  - 7-bit, free-running, advances every cycle.
  - Shift-left with feedback bit = lfsr[6] ^ lfsr[5] (x^7+x^6+1).
  - Never zero; period 127.
- Prescaler:
  - Counts 0..DIV-1; tick = 1 when the count equals DIV-1, then wraps to 0.
  - Forced to 0 on entry to DELAY and on entry to TIMING.
- States:
  - IDLE
    - start -> ARMED; clears jump_start. react_time is left unchanged.
  - ARMED
    - btn_rise -> set jump_start, go to IDLE.
    - Otherwise, lights == 8'hFF -> go to DELAY and load delay_cnt = MIN_DELAY + LFSR value sampled that cycle.
    - btn_rise has priority over lights == 8'hFF in the same cycle.
  - DELAY
    - btn_rise -> set jump_start, go to IDLE; no lights_off pulse.
    - Otherwise, on tick: decrement delay_cnt.
    - On the tick where delay_cnt is 1 -> pulse lights_off for one cycle (that same cycle), go to TIMING, clear the reaction counter.
    - btn_rise has priority over expiry in the same cycle.
  - TIMING
    - On tick: increment the reaction counter, saturating at all-ones (no wrap).
    - btn_rise -> react_time = counter value, pulse valid for one cycle, go to IDLE.
    - If btn_rise and tick coincide, the captured value is the pre-increment count.
- Other rules:
  - start outside IDLE is ignored.
  - The light pattern is ignored outside ARMED.
  - A lights pattern that drops from 8'hFF to 0 during DELAY has no effect.
  - Outputs are registered except busy, which is decoded from state.
- Latency:
  - lights_off is asserted (MIN_DELAY + lfsr) * DIV cycles after DELAY entry, within the DIV-1 cycle prescaler phase.
  - valid is asserted 1 cycle after the btn_rise edge.

Test Plan:
- Reset: DIV=4, MIN_DELAY=2. Hold rst high 2 cycles -> all outputs 0, busy 0, LFSR 7'h01; start while rst is high is ignored.
- Normal round:
  - Stimulus: DIV=4, MIN_DELAY=2; start, then lights = 8'hFF with a sampled LFSR value of L.
  - Expected: lights_off pulses exactly once, (2+L)*4 cycles after DELAY entry.
  - Then press the button 13 cycles later -> react_time = 3, valid is high for 1 cycle, busy goes to 0.
- Jump start in ARMED: button rises before lights = 8'hFF -> jump_start = 1, state IDLE, no lights_off, no valid, react_time unchanged.
- Jump start in DELAY: button rises mid-hold -> jump_start = 1, no lights_off. The next start clears jump_start to 0.
- Saturation: CNT_W=4, DIV=2; no button press for 40 cycles after lights_off -> counter holds 4'hF. The later press gives react_time = 15 and valid.
- Corner cases:
  - btn_rise and lights = 8'hFF in the same cycle in ARMED -> jump start wins.
  - Button held high across a start -> no event until it is released and pressed again.
  - rst asserted during TIMING -> IDLE with react_time = 0 and no valid pulse.
